// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM->WB elastic pipeline register.
package mem_wb_pkg;

    // Bit positions inside the WB control field.
    localparam int WB_REGWRITE_BIT = 0;
    localparam int WB_MEMTOREG_BIT = 1;

    // Default widths of the datapath carried through the slots.
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_WB_CTRL_W  = 2;

    // One in-flight MEM->WB entry at the default widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0]     read_data;
        logic [DEF_DATA_W-1:0]     alu_result;
        logic [DEF_REG_ADDR_W-1:0] write_dest;
        logic [DEF_WB_CTRL_W-1:0]  wb_ctrl;
    } wb_payload_t;

    // Write-back mux: loads return memory data, everything else the ALU result.
    function automatic logic [DEF_DATA_W-1:0] wb_select(input wb_payload_t p);
        return p.wb_ctrl[WB_MEMTOREG_BIT] ? p.read_data : p.alu_result;
    endfunction

endpackage

// File: rtl/mem_wb_slot.sv
// One elastic slot: a valid bit plus a payload register.
// clear drops the entry but leaves the payload untouched; load copies the
// upstream valid and, only when that entry is real, its payload, so the
// payload of an emptied slot stays bit-stable.
module mem_wb_slot #(
    parameter type payload_t = logic [31:0]
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     load,
    input  logic     valid_in,
    input  payload_t payload_in,
    output logic     valid,
    output payload_t payload
);

    // Valid/payload register with reset > clear > load priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (clear) begin
            valid   <= 1'b0;
        end else if (load) begin
            valid <= valid_in;
            if (valid_in) begin
                payload <= payload_in;
            end
        end
    end

endmodule

// File: rtl/mem_wb_elastic.sv
// MEM->WB pipeline register built from STAGES elastic slots.
// Handshake: an entry moves across a boundary on a clock edge in which the
// sender's valid and the receiver's ready are both 1; ready never depends on
// the sender's valid, and a sender holds its entry stable until it moves.
// Slot 0 is the youngest (fed by the input), slot STAGES-1 drives the outputs.
module mem_wb_elastic
    import mem_wb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int WB_CTRL_W  = DEF_WB_CTRL_W,
    parameter int STAGES     = 1,
    parameter int CNT_W      = 16,
    localparam int OCC_W     = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     read_data_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [REG_ADDR_W-1:0] write_dest_in,
    input  logic [WB_CTRL_W-1:0]  wb_ctrl_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] write_dest,
    output logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [OCC_W-1:0]      occupancy,
    output logic [CNT_W-1:0]      retired_count
);

    // Payload at this instance's widths; same layout as wb_payload_t.
    typedef struct packed {
        logic [DATA_W-1:0]     read_data;
        logic [DATA_W-1:0]     alu_result;
        logic [REG_ADDR_W-1:0] write_dest;
        logic [WB_CTRL_W-1:0]  wb_ctrl;
    } slot_payload_t;

    function automatic logic [DATA_W-1:0] select_wb(input slot_payload_t p);
        return p.wb_ctrl[WB_MEMTOREG_BIT] ? p.read_data : p.alu_result;
    endfunction

    logic          slot_valid [STAGES];
    slot_payload_t slot_pl    [STAGES];
    logic          src_valid  [STAGES];
    slot_payload_t src_pl     [STAGES];
    logic          adv        [STAGES];
    logic          next_valid [STAGES];
    logic [OCC_W-1:0] occ_next;
    slot_payload_t in_pl;
    slot_payload_t last_pl;

    assign in_pl   = '{read_data:  read_data_in,
                       alu_result: alu_result_in,
                       write_dest: write_dest_in,
                       wb_ctrl:    wb_ctrl_in};
    assign last_pl = slot_pl[STAGES-1];

    // Advance chain: slot i may move when out_ready=1 or any slot from i to
    // the output is empty, which collapses any bubble in a single cycle.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_full = all_full & slot_valid[i];
            adv[i]   = out_ready | ~all_full;
        end
    end

    // No skid buffer: ready is combinational from out_ready.
    assign in_ready = adv[0];

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_slot
            if (g == 0) begin : g_src_in
                assign src_valid[g] = in_valid;
                assign src_pl[g]    = in_pl;
            end else begin : g_src_prev
                assign src_valid[g] = slot_valid[g-1];
                assign src_pl[g]    = slot_pl[g-1];
            end

            mem_wb_slot #(
                .payload_t (slot_payload_t)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .clear      (flush),
                .load       (adv[g]),
                .valid_in   (src_valid[g]),
                .payload_in (src_pl[g]),
                .valid      (slot_valid[g]),
                .payload    (slot_pl[g])
            );
        end
    endgenerate

    // Next-state valid image of the slots, used only to register occupancy.
    always_comb begin
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            next_valid[i] = flush ? 1'b0 : (adv[i] ? src_valid[i] : slot_valid[i]);
            occ_next      = occ_next + OCC_W'(next_valid[i]);
        end
    end

    // Occupancy register: popcount of the valid bits after each edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

    // Write-back outputs from the oldest slot; flush suppresses the write.
    assign out_valid  = slot_valid[STAGES-1];
    assign wb_data    = select_wb(last_pl);
    assign write_dest = last_pl.write_dest;
    assign reg_write  = out_valid & out_ready & ~flush & last_pl.wb_ctrl[WB_REGWRITE_BIT];

    // Retired-write counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
        end else if (reg_write) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (slot_valid[i] && slot_pl[i].wb_ctrl[WB_REGWRITE_BIT] &&
                (slot_pl[i].write_dest == fwd_addr) && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = select_wb(slot_pl[i]);
            end
        end
    end

endmodule
